// File: rtl/vga_frame_reader.sv
// vga_frame_reader: reads a square grayscale frame from RAM in raster order
// and drives VGA timing with the image centred. Latency: 3 cycles from the
// counter value to every VGA output. There is no backpressure: it free-runs.
//
// Ports:
//   CLK, RST        pixel clock, synchronous active-high reset
//   FILL_DONE       level from the writer, high = RAM holds a complete frame
//   RD_ADDR, RD_EN  RAM read port {row, col}; RD_EN high for displayed pixels
//   RD_DATA         RAM q, valid one cycle after RD_ADDR
//   VGA_EN          active-video qualifier
//   VGA_DATA        pixel value
//   HSYNC, VSYNC    active-low syncs
//   FRAME_START     one-cycle pulse with output pixel (0,0)
module vga_frame_reader #(
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_X0   = 192,
  parameter int IMG_Y0   = 112,
  parameter logic [D_WIDTH-1:0] BORDER = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FILL_DONE,
  output logic [A_WIDTH-1:0] RD_ADDR,
  output logic               RD_EN,
  input  logic [D_WIDTH-1:0] RD_DATA,
  output logic               VGA_EN,
  output logic [D_WIDTH-1:0] VGA_DATA,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               FRAME_START
);

  localparam int HALF    = A_WIDTH / 2;
  localparam int S       = 1 << HALF;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t state, state_nxt;

  // Stage 0: raster counters
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [31:0]   hh, vv;
  logic          h_last, v_last;

  assign hh     = 32'(h);
  assign vv     = 32'(v);
  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      if (v_last) v <= '0;
      else        v <= v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Display state only moves at the frame boundary so a frame is never torn;
  // the new state applies from the following pixel (0,0).
  always_ff @(posedge CLK) begin
    if (RST) state <= BLANK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (h_last && v_last) begin
      case (state)
        BLANK:   if (FILL_DONE)  state_nxt = SHOW;
        SHOW:    if (!FILL_DONE) state_nxt = BLANK;
        default: state_nxt = BLANK;
      endcase
    end
  end

  // Stage 0 decode
  logic            s0_active, s0_win, s0_read, s0_hs, s0_vs, s0_fs;
  logic [HALF-1:0] s0_col, s0_row;

  assign s0_active = (hh < H_ACTIVE) && (vv < V_ACTIVE);
  assign s0_win    = (hh >= IMG_X0) && (hh < IMG_X0 + S) &&
                     (vv >= IMG_Y0) && (vv < IMG_Y0 + S);
  assign s0_read   = s0_win && (state == SHOW);
  assign s0_hs     = !((hh >= H_ACTIVE + H_FP) && (hh < H_ACTIVE + H_FP + H_SYNC));
  assign s0_vs     = !((vv >= V_ACTIVE + V_FP) && (vv < V_ACTIVE + V_FP + V_SYNC));
  assign s0_fs     = (h == '0) && (v == '0);
  assign s0_col    = HALF'(hh - 32'(IMG_X0));
  assign s0_row    = HALF'(vv - 32'(IMG_Y0));

  // Stage 1: RAM request plus delayed qualifiers. RD_EN doubles as the
  // "show this pixel from RAM" flag for the later stages.
  logic s1_active, s1_hs, s1_vs, s1_fs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_ADDR   <= '0;
      RD_EN     <= 1'b0;
      s1_active <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_fs     <= 1'b0;
    end else begin
      // Address holds outside displayed pixels to avoid needless RAM toggling.
      if (s0_read) RD_ADDR <= {s0_row, s0_col};
      RD_EN     <= s0_read;
      s1_active <= s0_active;
      s1_hs     <= s0_hs;
      s1_vs     <= s0_vs;
      s1_fs     <= s0_fs;
    end
  end

  // Stage 2: RAM q becomes valid; qualifiers wait alongside it.
  logic s2_active, s2_read, s2_hs, s2_vs, s2_fs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_active <= 1'b0;
      s2_read   <= 1'b0;
      s2_hs     <= 1'b1;
      s2_vs     <= 1'b1;
      s2_fs     <= 1'b0;
    end else begin
      s2_active <= s1_active;
      s2_read   <= RD_EN;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      s2_fs     <= s1_fs;
    end
  end

  // Stage 3: registered VGA outputs, all aligned.
  always_ff @(posedge CLK) begin
    if (RST) begin
      VGA_EN      <= 1'b0;
      VGA_DATA    <= '0;
      HSYNC       <= 1'b1;
      VSYNC       <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      VGA_EN      <= s2_active;
      if (s2_read)        VGA_DATA <= RD_DATA;
      else if (s2_active) VGA_DATA <= BORDER;
      else                VGA_DATA <= '0;
      HSYNC       <= s2_hs;
      VSYNC       <= s2_vs;
      FRAME_START <= s2_fs;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
`timescale 1ns/1ps
module tb_vga_frame_reader;

  // Reduced timing so several whole frames fit in a short run.
  localparam int AW  = 8;
  localparam int HA  = 40, HFP = 4, HS = 8, HBP = 4;
  localparam int VA  = 30, VFP = 2, VS = 2, VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;   // 56
  localparam int VT  = VA + VFP + VS + VBP;   // 36
  localparam int FL  = HT * VT;               // 2016
  localparam int X0  = 12, Y0 = 7;
  localparam int S   = 16;
  localparam logic [7:0] BRD = 8'h5A;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FILL_DONE;
  logic [AW-1:0] RD_ADDR;
  logic          RD_EN;
  logic [7:0]    RD_DATA;
  logic          VGA_EN;
  logic [7:0]    VGA_DATA;
  logic          HSYNC, VSYNC, FRAME_START;

  always #5 CLK = ~CLK;

  vga_frame_reader #(
    .D_WIDTH(8), .A_WIDTH(AW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .IMG_X0(X0), .IMG_Y0(Y0), .BORDER(BRD)
  ) dut (
    .CLK(CLK), .RST(RST), .FILL_DONE(FILL_DONE),
    .RD_ADDR(RD_ADDR), .RD_EN(RD_EN), .RD_DATA(RD_DATA),
    .VGA_EN(VGA_EN), .VGA_DATA(VGA_DATA),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .FRAME_START(FRAME_START)
  );

  // RAM model: q = address low byte, one cycle after the address.
  always @(posedge CLK) RD_DATA <= RD_ADDR;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] exp_addr;
  int bad_total, bad_en, bad_dat, bad_hs, bad_vs, bad_fs, bad_rden, bad_addr, first_bad;
  logic [7:0] cap_tl, cap_tr, cap_l, cap_r;
  logic [AW-1:0] first_rd, last_rd;
  int n_rd;

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Walks one frame of outputs starting at output pixel (0,0), tallying
  // mismatches against the expected raster. RD_ADDR/RD_EN lead the outputs
  // by two pixels. Optionally changes FILL_DONE at column 0 of chg_line.
  task automatic scan_frame(input bit show, input int chg_line, input bit fd_new);
    int x, y, q, qx, qy;
    bit act, win, qwin, ehs, evs, efs, erd;
    logic [7:0] edat;
    bad_en = 0; bad_dat = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0;
    bad_rden = 0; bad_addr = 0; first_bad = -1; n_rd = 0;
    for (int p = 0; p < FL; p++) begin
      x = p % HT;
      y = p / HT;
      act  = (x < HA) && (y < VA);
      win  = (x >= X0) && (x < X0 + S) && (y >= Y0) && (y < Y0 + S);
      edat = !act ? 8'h00 : ((show && win) ? 8'((y - Y0) * S + (x - X0)) : BRD);
      ehs  = !((x >= HA + HFP) && (x < HA + HFP + HS));
      evs  = !((y >= VA + VFP) && (y < VA + VFP + VS));
      efs  = (p == 0);
      q    = (p + 2) % FL;
      qx   = q % HT;
      qy   = q / HT;
      qwin = (qx >= X0) && (qx < X0 + S) && (qy >= Y0) && (qy < Y0 + S);
      erd  = show && qwin;
      if (erd) exp_addr = AW'((qy - Y0) * S + (qx - X0));
      if (VGA_EN !== act)      begin bad_en++;   if (first_bad < 0) first_bad = p; end
      if (VGA_DATA !== edat)   begin bad_dat++;  if (first_bad < 0) first_bad = p; end
      if (HSYNC !== ehs)       begin bad_hs++;   if (first_bad < 0) first_bad = p; end
      if (VSYNC !== evs)       begin bad_vs++;   if (first_bad < 0) first_bad = p; end
      if (FRAME_START !== efs) begin bad_fs++;   if (first_bad < 0) first_bad = p; end
      if (RD_EN !== erd)       begin bad_rden++; if (first_bad < 0) first_bad = p; end
      if (RD_ADDR !== exp_addr) begin bad_addr++; if (first_bad < 0) first_bad = p; end
      if (y == Y0 && x == X0)         cap_tl = VGA_DATA;
      if (y == Y0 && x == X0 + S - 1) cap_tr = VGA_DATA;
      if (y == Y0 && x == X0 - 1)     cap_l  = VGA_DATA;
      if (y == Y0 && x == X0 + S)     cap_r  = VGA_DATA;
      if (RD_EN === 1'b1) begin
        if (n_rd == 0) first_rd = RD_ADDR;
        last_rd = RD_ADDR;
        n_rd++;
      end
      if (chg_line >= 0 && y == chg_line && x == 0) FILL_DONE = fd_new;
      tick();
    end
    bad_total = bad_en + bad_dat + bad_hs + bad_vs + bad_fs + bad_rden + bad_addr;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    FILL_DONE = 1'b0;
    exp_addr = '0;
    repeat (3) tick();
    checks++; if (VGA_EN !== 1'b0)      begin errors++; $display("FAIL reset_vga_en: got %b required 0", VGA_EN); end
    checks++; if (VGA_DATA !== 8'h00)   begin errors++; $display("FAIL reset_vga_data: got %02h required 00", VGA_DATA); end
    checks++; if (HSYNC !== 1'b1)       begin errors++; $display("FAIL reset_hsync: got %b required 1", HSYNC); end
    checks++; if (VSYNC !== 1'b1)       begin errors++; $display("FAIL reset_vsync: got %b required 1", VSYNC); end
    checks++; if (FRAME_START !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b required 0", FRAME_START); end
    checks++; if (RD_EN !== 1'b0)       begin errors++; $display("FAIL reset_rd_en: got %b required 0", RD_EN); end
    checks++; if (RD_ADDR !== 8'h00)    begin errors++; $display("FAIL reset_rd_addr: got %02h required 00", RD_ADDR); end
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({VGA_EN, FRAME_START, HSYNC} !== 3'b001) begin
        errors++;
        $display("FAIL release_latency cycle %0d: got en/fs/hs=%b required 001", k, {VGA_EN, FRAME_START, HSYNC});
      end
      tick();
    end
    checks++;
    if ({VGA_EN, FRAME_START} !== 2'b11) begin
      errors++;
      $display("FAIL first_pixel: got en/fs=%b required 11", {VGA_EN, FRAME_START});
    end
  endtask

  task automatic test_blank_then_rise;
    // FILL_DONE rises mid-frame: this frame stays blank.
    scan_frame(1'b0, 15, 1'b1);
    checks++; if (bad_total !== 0) begin errors++;
      $display("FAIL blank_frame: mismatches=%0d (en %0d dat %0d hs %0d vs %0d fs %0d rden %0d addr %0d) first pixel %0d, required 0",
               bad_total, bad_en, bad_dat, bad_hs, bad_vs, bad_fs, bad_rden, bad_addr, first_bad); end
    checks++; if (n_rd !== 0) begin errors++; $display("FAIL blank_rd_en: got %0d reads required 0", n_rd); end
    checks++; if (cap_tl !== BRD) begin errors++; $display("FAIL blank_window_border: got %02h required %02h", cap_tl, BRD); end
  endtask

  task automatic test_show_frame;
    scan_frame(1'b1, -1, 1'b1);
    checks++; if (bad_total !== 0) begin errors++;
      $display("FAIL show_frame: mismatches=%0d (en %0d dat %0d hs %0d vs %0d fs %0d rden %0d addr %0d) first pixel %0d, required 0",
               bad_total, bad_en, bad_dat, bad_hs, bad_vs, bad_fs, bad_rden, bad_addr, first_bad); end
    checks++; if (cap_tl !== 8'h00) begin errors++; $display("FAIL show_top_left: got %02h required 00", cap_tl); end
    checks++; if (cap_tr !== 8'h0F) begin errors++; $display("FAIL show_top_right: got %02h required 0f", cap_tr); end
    checks++; if (cap_l !== BRD)    begin errors++; $display("FAIL show_left_border: got %02h required %02h", cap_l, BRD); end
    checks++; if (cap_r !== BRD)    begin errors++; $display("FAIL show_right_border: got %02h required %02h", cap_r, BRD); end
    checks++; if (first_rd !== 8'h00) begin errors++; $display("FAIL show_first_addr: got %02h required 00", first_rd); end
    checks++; if (last_rd !== 8'hFF)  begin errors++; $display("FAIL show_last_addr: got %02h required ff", last_rd); end
    checks++; if (n_rd !== S * S)     begin errors++; $display("FAIL show_read_count: got %0d required %0d", n_rd, S * S); end
  endtask

  task automatic test_drop_mid;
    // Drop inside the image window: the rest of this frame still shows.
    scan_frame(1'b1, 20, 1'b0);
    checks++; if (bad_total !== 0) begin errors++;
      $display("FAIL drop_frame: mismatches=%0d (dat %0d rden %0d addr %0d) first pixel %0d, required 0",
               bad_total, bad_dat, bad_rden, bad_addr, first_bad); end
    checks++; if (n_rd !== S * S) begin errors++; $display("FAIL drop_frame_reads: got %0d required %0d", n_rd, S * S); end
    // Next frame all border; FILL_DONE rises again partway through it.
    scan_frame(1'b0, 15, 1'b1);
    checks++; if (bad_total !== 0) begin errors++;
      $display("FAIL after_drop_frame: mismatches=%0d (dat %0d rden %0d addr %0d) first pixel %0d, required 0",
               bad_total, bad_dat, bad_rden, bad_addr, first_bad); end
    checks++; if (n_rd !== 0) begin errors++; $display("FAIL after_drop_rd_en: got %0d reads required 0", n_rd); end
  endtask

  task automatic test_rise_mid;
    scan_frame(1'b1, -1, 1'b1);
    checks++; if (bad_total !== 0) begin errors++;
      $display("FAIL rise_next_frame: mismatches=%0d (dat %0d rden %0d addr %0d) first pixel %0d, required 0",
               bad_total, bad_dat, bad_rden, bad_addr, first_bad); end
    checks++; if (cap_tl !== 8'h00) begin errors++; $display("FAIL rise_top_left: got %02h required 00", cap_tl); end
  endtask

  task automatic test_frame_period;
    int cnt;
    checks++; if (FRAME_START !== 1'b1) begin errors++; $display("FAIL period_start: got %b required 1", FRAME_START); end
    for (int f = 0; f < 3; f++) begin
      tick();
      cnt = 1;
      while (FRAME_START !== 1'b1 && cnt < 2 * FL) begin
        tick();
        cnt++;
      end
      checks++;
      if (cnt !== FL) begin errors++; $display("FAIL frame_period %0d: got %0d cycles required %0d", f, cnt, FL); end
    end
  endtask

  task automatic test_mid_reset;
    // Land on an in-window pixel of a showing frame so the pipeline holds image data.
    repeat (15 * HT + 20) tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({VGA_EN, VGA_DATA, HSYNC, VSYNC, FRAME_START, RD_EN, RD_ADDR} !== {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset_outputs: got en=%b dat=%02h hs=%b vs=%b fs=%b rden=%b addr=%02h required en=0 dat=00 hs=1 vs=1 fs=0 rden=0 addr=00",
               VGA_EN, VGA_DATA, HSYNC, VSYNC, FRAME_START, RD_EN, RD_ADDR);
    end
    RST = 1'b0;
    exp_addr = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({VGA_EN, VGA_DATA, FRAME_START} !== 10'h000) begin
        errors++;
        $display("FAIL mid_reset_flush cycle %0d: got en=%b dat=%02h fs=%b required 0/00/0", k, VGA_EN, VGA_DATA, FRAME_START);
      end
    end
    tick();
    checks++; if (FRAME_START !== 1'b1) begin errors++; $display("FAIL mid_reset_frame_start: got %b required 1", FRAME_START); end
    // State restarts in BLANK even though FILL_DONE is high.
    scan_frame(1'b0, -1, 1'b1);
    checks++; if (bad_total !== 0) begin errors++;
      $display("FAIL post_reset_blank: mismatches=%0d (dat %0d rden %0d addr %0d) first pixel %0d, required 0",
               bad_total, bad_dat, bad_rden, bad_addr, first_bad); end
    scan_frame(1'b1, -1, 1'b1);
    checks++; if (bad_total !== 0) begin errors++;
      $display("FAIL post_reset_show: mismatches=%0d (dat %0d rden %0d addr %0d) first pixel %0d, required 0",
               bad_total, bad_dat, bad_rden, bad_addr, first_bad); end
  endtask

  initial begin
    RST = 1'b1;
    FILL_DONE = 1'b0;
    @(negedge CLK);
    test_reset();
    test_blank_then_rise();
    test_show_frame();
    test_drop_mid();
    test_rise_mid();
    test_frame_period();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
